mc_controller: RTL and testbench

Control unit for the multicycle RISC-V core: a Moore main FSM plus ALU and immediate decoders that sequence the shared datapath (single unified memory, one ALU, PC/OldPC, IR, A/B, ALUOut and Data registers) through fetch, decode and execute. It sits beside the datapath inside the core under `top`. It takes the opcode fields from the instruction register and the ALU Zero flag, and drives every mux select and write enable. Supported instructions: lw, sw, R-type (add, sub, and, or, slt), I-type ALU (addi, andi, ori, slti), beq, jal.

---
 rtl/mc_controller.sv | 213 +++++++++++++++++++++
 tb/tb_mc_controller.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_controller.sv
// Control unit for the multicycle RISC-V core: Moore main FSM plus ALU and immediate decoders.
// Latency: outputs are combinational from the current state and instruction fields (same cycle).
// Backpressure: none; the FSM advances every clock, and write enables are gated low during reset.
module mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       RegWrite,
  output logic [3:0] state
);

  // Opcodes recognised by the decoder
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  // Internal ALU operation class handed from the FSM to the ALU decoder
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  state_t cur_state;
  state_t nxt_state;

  aluop_t alu_op;
  logic   pc_update;
  logic   branch;
  logic   adr_src;
  logic   mem_write_raw;
  logic   ir_write_raw;
  logic   reg_write_raw;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;

  // State register: asynchronous return to FETCH whenever reset is asserted
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_state <= S_FETCH;
    end else begin
      cur_state <= nxt_state;
    end
  end

  // Next-state logic; unsupported opcodes and unused encodings fall back to FETCH
  always_comb begin
    nxt_state = S_FETCH;
    case (cur_state)
      S_FETCH:  nxt_state = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: nxt_state = S_MEMADR;
          OP_RTYPE:          nxt_state = S_EXECR;
          OP_ITYPE:          nxt_state = S_EXECI;
          OP_JAL:            nxt_state = S_JAL;
          OP_BRANCH:         nxt_state = S_BEQ;
          default:           nxt_state = S_FETCH;
        endcase
      end
      S_MEMADR:   nxt_state = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  nxt_state = S_MEMWB;
      S_MEMWB:    nxt_state = S_FETCH;
      S_MEMWRITE: nxt_state = S_FETCH;
      S_EXECR:    nxt_state = S_ALUWB;
      S_EXECI:    nxt_state = S_ALUWB;
      S_ALUWB:    nxt_state = S_FETCH;
      S_JAL:      nxt_state = S_ALUWB;
      S_BEQ:      nxt_state = S_FETCH;
      default:    nxt_state = S_FETCH;
    endcase
  end

  // Moore output table: selects and raw enables for each state
  always_comb begin
    alu_op        = ALUOP_ADD;
    pc_update     = 1'b0;
    branch        = 1'b0;
    adr_src       = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    result_src    = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    case (cur_state)
      S_FETCH: begin
        ir_write_raw = 1'b1;
        alu_src_b    = 2'b10;
        result_src   = 2'b10;
        pc_update    = 1'b1;
      end
      S_DECODE: begin
        // Branch target is precomputed here from OldPC + immediate
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src    = 2'b01;
        reg_write_raw = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src       = 1'b1;
        mem_write_raw = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_write_raw = 1'b1;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
      end
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = ALUOP_SUB;
        branch    = 1'b1;
      end
      default: begin
        alu_op = ALUOP_ADD;
      end
    endcase
  end

  // ALU decoder: funct-class operations pick the function from funct3/funct7
  always_comb begin
    ALUControl = 3'b000;
    case (alu_op)
      ALUOP_ADD: ALUControl = 3'b000;
      ALUOP_SUB: ALUControl = 3'b001;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  // Immediate format decoder, independent of the FSM state
  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      OP_LOAD, OP_ITYPE: ImmSrc = 2'b00;
      OP_STORE:          ImmSrc = 2'b01;
      OP_BRANCH:         ImmSrc = 2'b10;
      OP_JAL:            ImmSrc = 2'b11;
      default:           ImmSrc = 2'b00;
    endcase
  end

  // Enables are masked by reset so nothing can write while the core is held
  assign PCWrite   = reset & (pc_update | (branch & Zero));
  assign IRWrite   = reset & ir_write_raw;
  assign RegWrite  = reset & reg_write_raw;
  assign MemWrite  = reset & mem_write_raw;
  assign AdrSrc    = adr_src;
  assign ResultSrc = result_src;
  assign ALUSrcA   = alu_src_a;
  assign ALUSrcB   = alu_src_b;
  assign state     = cur_state;

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: instruction-level state sequences plus per-state output table model.
// Latency: expected outputs are compared on the falling edge of every checked cycle.
// Backpressure: none; stimulus advances one instruction at a time.
module tb_mc_controller;

  logic       clk;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] state;

  int n_chk  = 0;
  int n_fail = 0;

  int q_exp[$];
  int memw_cycles, regw_cycles;
  logic [2:0] snap_alu [16];
  logic       snap_pcw [16];
  logic [1:0] snap_res [16];
  logic       snap_adr [16];
  logic [1:0] snap_imm [16];

  mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .RegWrite(RegWrite), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction-level model: which states an instruction walks through
  function automatic void push_seq(input logic [6:0] o);
    q_exp.push_back(0);
    q_exp.push_back(1);
    if (o == 7'b0000011) begin
      q_exp.push_back(2); q_exp.push_back(3); q_exp.push_back(4);
    end else if (o == 7'b0100011) begin
      q_exp.push_back(2); q_exp.push_back(5);
    end else if (o == 7'b0110011) begin
      q_exp.push_back(6); q_exp.push_back(7);
    end else if (o == 7'b0010011) begin
      q_exp.push_back(8); q_exp.push_back(7);
    end else if (o == 7'b1101111) begin
      q_exp.push_back(9); q_exp.push_back(7);
    end else if (o == 7'b1100011) begin
      q_exp.push_back(10);
    end
  endfunction

  function automatic int seq_len(input logic [6:0] o);
    case (o)
      7'b0000011: return 5;
      7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111: return 4;
      7'b1100011: return 3;
      default: return 2;
    endcase
  endfunction

  // ALU function requested by an arithmetic instruction
  function automatic logic [2:0] arith_ctl(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    if (f3 == 3'b000) return (o == 7'b0110011 && f7) ? 3'b001 : 3'b000;
    if (f3 == 3'b010) return 3'b101;
    if (f3 == 3'b110) return 3'b011;
    if (f3 == 3'b111) return 3'b010;
    return 3'b000;
  endfunction

  // Expected output vector {state,PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,ALUControl,RegWrite}
  function automatic logic [19:0] exp_vec(input int st, input logic [6:0] o, input logic [2:0] f3,
                                          input logic f7, input logic z);
    logic pcw, adr, mw, irw, rw;
    logic [1:0] res, sa, sb, imm;
    logic [2:0] ac;
    pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; res = 0; sa = 0; sb = 0; ac = 0;
    if (o == 7'b0100011) imm = 2'b01;
    else if (o == 7'b1100011) imm = 2'b10;
    else if (o == 7'b1101111) imm = 2'b11;
    else imm = 2'b00;
    case (st)
      0:  begin irw = 1; sb = 2'b10; res = 2'b10; pcw = 1; end
      1:  begin sa = 2'b01; sb = 2'b01; end
      2:  begin sa = 2'b10; sb = 2'b01; end
      3:  adr = 1;
      4:  begin res = 2'b01; rw = 1; end
      5:  begin adr = 1; mw = 1; end
      6:  begin sa = 2'b10; ac = arith_ctl(o, f3, f7); end
      7:  rw = 1;
      8:  begin sa = 2'b10; sb = 2'b01; ac = arith_ctl(o, f3, f7); end
      9:  begin sa = 2'b01; sb = 2'b10; pcw = 1; end
      10: begin sa = 2'b10; ac = 3'b001; pcw = z; end
      default: ;
    endcase
    return {st[3:0], pcw, adr, mw, irw, res, sa, sb, imm, ac, rw};
  endfunction

  // Compare process: every cycle with a queued expectation is checked against the model
  always @(negedge clk) begin
    if (reset) begin
      if (MemWrite) memw_cycles++;
      if (RegWrite) regw_cycles++;
      if (q_exp.size() > 0) begin
        int st;
        logic [19:0] ev, av;
        st = q_exp.pop_front();
        ev = exp_vec(st, op, funct3, funct7b5, Zero);
        av = {state, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
              ImmSrc, ALUControl, RegWrite};
        n_chk++;
        if (av !== ev) begin
          n_fail++;
          $display("FAIL cycle_outputs op=%b f3=%b z=%b got=%h want=%h", op, funct3, Zero, av, ev);
        end
        snap_alu[state] = ALUControl;
        snap_pcw[state] = PCWrite;
        snap_res[state] = ResultSrc;
        snap_adr[state] = AdrSrc;
        snap_imm[state] = ImmSrc;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", nm, act, want);
    end
  endtask

  task automatic clr_snap();
    for (int i = 0; i < 16; i++) begin
      snap_alu[i] = 'x; snap_pcw[i] = 'x; snap_res[i] = 'x; snap_adr[i] = 'x; snap_imm[i] = 'x;
    end
    memw_cycles = 0;
    regw_cycles = 0;
  endtask

  // Runs one instruction from its FETCH cycle; zm 0/1 forces Zero, 2 randomises it
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7, input int zm);
    int n;
    clr_snap();
    op = o; funct3 = f3; funct7b5 = f7;
    push_seq(o);
    n = seq_len(o);
    for (int i = 0; i < n; i++) begin
      Zero = (zm == 2) ? 1'($urandom_range(0, 1)) : 1'(zm);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [6:0] ops [7];
    ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b0110011; ops[3] = 7'b0010011;
    ops[4] = 7'b1101111; ops[5] = 7'b1100011; ops[6] = 7'b0000000;
    memw_cycles = 0; regw_cycles = 0;

    // Reset held for two cycles
    reset = 1'b0; op = 7'b0100011; funct3 = 3'b000; funct7b5 = 1'b0; Zero = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state", state, 0);
    chk("reset_enables", {PCWrite, IRWrite, RegWrite, MemWrite}, 4'b0000);
    chk("reset_alusrcb", ALUSrcB, 2'b10);
    chk("reset_resultsrc", ResultSrc, 2'b10);
    chk("reset_aluctl", ALUControl, 3'b000);
    chk("reset_immsrc", ImmSrc, 2'b01);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("fetch_irwrite", IRWrite, 1);
    chk("fetch_pcwrite", PCWrite, 1);
    chk("fetch_alusrcb", ALUSrcB, 2'b10);

    // lw
    run_instr(7'b0000011, 3'b010, 1'b0, 2);
    chk("lw_regwrite_cycles", regw_cycles, 1);
    chk("lw_memwb_resultsrc", snap_res[4], 2'b01);
    chk("lw_memread_adrsrc", snap_adr[3], 1);
    // sw
    run_instr(7'b0100011, 3'b010, 1'b0, 2);
    chk("sw_memwrite_cycles", memw_cycles, 1);
    chk("sw_immsrc", snap_imm[5], 2'b01);
    // R-type variants
    run_instr(7'b0110011, 3'b000, 1'b1, 2);
    chk("sub_aluctl", snap_alu[6], 3'b001);
    run_instr(7'b0110011, 3'b000, 1'b0, 2);
    chk("add_aluctl", snap_alu[6], 3'b000);
    run_instr(7'b0110011, 3'b111, 1'b0, 2);
    chk("and_aluctl", snap_alu[6], 3'b010);
    run_instr(7'b0110011, 3'b110, 1'b0, 2);
    chk("or_aluctl", snap_alu[6], 3'b011);
    run_instr(7'b0110011, 3'b010, 1'b0, 2);
    chk("slt_aluctl", snap_alu[6], 3'b101);
    run_instr(7'b0010011, 3'b000, 1'b1, 2);
    chk("addi_f7_ignored", snap_alu[8], 3'b000);
    // beq taken / not taken
    run_instr(7'b1100011, 3'b000, 1'b0, 1);
    chk("beq_taken_pcwrite", snap_pcw[10], 1);
    chk("beq_aluctl", snap_alu[10], 3'b001);
    run_instr(7'b1100011, 3'b000, 1'b0, 0);
    chk("beq_nottaken_pcwrite", snap_pcw[10], 0);
    // jal then unsupported op
    run_instr(7'b1101111, 3'b000, 1'b0, 2);
    chk("jal_pcwrite", snap_pcw[9], 1);
    chk("jal_immsrc", snap_imm[9], 2'b11);
    chk("jal_regwrite_cycles", regw_cycles, 1);
    run_instr(7'b0000000, 3'b000, 1'b0, 2);
    chk("illegal_regwrite_cycles", regw_cycles, 0);
    chk("illegal_memwrite_cycles", memw_cycles, 0);

    // Reset asserted in the middle of MEMWRITE
    clr_snap();
    op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0; Zero = 1'b0;
    push_seq(op);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("midreset_pre_memwrite", MemWrite, 1);
    reset = 1'b0;
    #1;
    chk("midreset_memwrite_drop", MemWrite, 0);
    chk("midreset_state", state, 0);
    chk("midreset_enables", {PCWrite, IRWrite, RegWrite}, 3'b000);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("midreset_release_state", state, 0);
    chk("midreset_release_irwrite", IRWrite, 1);

    // Randomised instruction stream
    for (int k = 0; k < 300; k++) begin
      int kind;
      logic [6:0] o;
      kind = $urandom_range(0, 7);
      o = (kind == 7) ? 7'($urandom_range(0, 127)) : ops[kind];
      run_instr(o, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 2);
    end
    chk("queue_drained", q_exp.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
